// File: rtl/systolic_drain.sv
// Drains an N x N systolic-array result: waits LAT enabled cycles, snapshots the
// array, then streams the N*N elements out over a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no drain in progress, waiting for i_start
// WAIT  | counting enabled cycles until the array result is stable
// SEND  | presenting snapshot element idx, advancing on each transfer
// DONE  | one-cycle completion pulse, then back to IDLE
module systolic_drain #(
   parameter int W   = 32,
   parameter int N   = 3,
   parameter int LAT = 7,
   parameter int IW  = ((N * N) > 1) ? $clog2(N * N) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic                 i_start,
   input  logic [2*W*N*N-1:0]   i_C,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [2*W-1:0]       o_data,
   output logic [IW-1:0]        o_idx,
   output logic                 o_last,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam int EW = 2 * W;
   localparam logic [CW-1:0] CNT_TC  = CW'(LAT - 1);
   localparam logic [IW-1:0] IDX_END = IW'(N * N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q;
   logic [IW-1:0]       idx_q;
   logic [EW*N*N-1:0]   snap_q;

   logic cnt_hit;
   logic xfer;
   logic idx_end;

   assign cnt_hit = i_en && (cnt_q == CNT_TC);
   assign idx_end = (idx_q == IDX_END);
   assign xfer    = (state_q == SEND) && i_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = WAIT;
         WAIT:    if (cnt_hit) state_d = SEND;
         SEND:    if (xfer && idx_end) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The snapshot decouples the output stream from the live array bus.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         snap_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) cnt_q <= '0;
            end
            WAIT: begin
               if (i_en) cnt_q <= cnt_q + 1'b1;
               if (cnt_hit) begin
                  snap_q <= i_C;
                  idx_q  <= '0;
               end
            end
            SEND: begin
               if (xfer && !idx_end) idx_q <= idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_valid = 1'b0;
      o_data  = '0;
      o_idx   = '0;
      o_last  = 1'b0;
      o_busy  = (state_q != IDLE);
      o_done  = (state_q == DONE);
      if (state_q == SEND) begin
         o_valid = 1'b1;
         o_data  = snap_q[idx_q*EW +: EW];
         o_idx   = idx_q;
         o_last  = idx_end;
      end
   end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: reset, basic drain, enable stall,
// backpressure, snapshot isolation with ignored start, and mid-drain reset.
module tb_systolic_drain;

   localparam int W   = 32;
   localparam int N   = 3;
   localparam int LAT = 7;
   localparam int IW  = 4;
   localparam int NE  = N * N;

   logic                 i_clk;
   logic                 i_rst;
   logic                 i_en;
   logic                 i_start;
   logic [2*W*NE-1:0]    i_C;
   logic                 o_valid;
   logic                 i_ready;
   logic [2*W-1:0]       o_data;
   logic [IW-1:0]        o_idx;
   logic                 o_last;
   logic                 o_busy;
   logic                 o_done;

   int checks = 0;
   int errors = 0;
   logic [2*W*NE-1:0] c_base;

   systolic_drain #(.W(W), .N(N), .LAT(LAT)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_start (i_start),
      .i_C     (i_C),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_idx   (o_idx),
      .o_last  (o_last),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, 64'(o_valid), 64'd0);
      chk({tag, "_data"},  o_data,       64'd0);
      chk({tag, "_idx"},   64'(o_idx),   64'd0);
      chk({tag, "_last"},  64'(o_last),  64'd0);
   endtask

   // Runs one drain from IDLE; all driving and sampling happens on negedges.
   task automatic drain(input string tag, input int stall_from, input int stall_len,
                        input int bp_hold, input bit snap_test, input int exp_rise);
      int edges;
      int k;
      int hold;
      i_start = 1'b1;
      i_en    = 1'b1;
      i_ready = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      edges   = 0;
      chk({tag, "_busy_wait"}, 64'(o_busy), 64'd1);
      while (!o_valid && edges < 50) begin
         i_en = (edges >= stall_from && edges < stall_from + stall_len) ? 1'b0 : 1'b1;
         chk_idle_outputs({tag, "_wait"});
         @(negedge i_clk);
         edges++;
      end
      i_en = 1'b1;
      chk({tag, "_rise_edge"}, 64'(edges), 64'(exp_rise));
      k    = 0;
      hold = 0;
      while (k < NE) begin
         if (snap_test && k == 0) i_C = '1;
         chk({tag, "_valid"}, 64'(o_valid), 64'd1);
         chk({tag, "_data"},  o_data,       64'(k + 1));
         chk({tag, "_idx"},   64'(o_idx),   64'(k));
         chk({tag, "_last"},  64'(o_last),  64'(k == NE - 1));
         chk({tag, "_nodone"}, 64'(o_done), 64'd0);
         if (k == 4 && hold < bp_hold) begin
            i_ready = 1'b0;
            hold++;
         end else begin
            i_ready = 1'b1;
            k++;
         end
         i_start = snap_test && (k == 3);
         @(negedge i_clk);
      end
      i_start = 1'b0;
      chk({tag, "_done"},      64'(o_done),  64'd1);
      chk({tag, "_done_busy"}, 64'(o_busy),  64'd1);
      chk_idle_outputs({tag, "_done"});
      @(negedge i_clk);
      chk({tag, "_done_end"},  64'(o_done),  64'd0);
      chk({tag, "_idle_busy"}, 64'(o_busy),  64'd0);
      chk_idle_outputs({tag, "_idle"});
      i_C = c_base;
   endtask

   initial begin
      int edges;
      for (int k = 0; k < NE; k++) c_base[k*2*W +: 2*W] = 64'(k + 1);

      // Reset with random start and array data
      i_rst   = 1'b0;
      i_en    = 1'b1;
      i_ready = 1'b1;
      i_start = 1'($urandom_range(0, 1));
      i_C     = {18{$urandom()}};
      for (int c = 0; c < 2; c++) begin
         @(negedge i_clk);
         chk_idle_outputs("rst");
         chk("rst_busy", 64'(o_busy), 64'd0);
         chk("rst_done", 64'(o_done), 64'd0);
         i_start = 1'($urandom_range(0, 1));
         i_C     = {18{$urandom()}};
      end
      i_start = 1'b0;
      i_C     = c_base;
      i_rst   = 1'b1;
      @(negedge i_clk);
      chk("post_rst_busy", 64'(o_busy), 64'd0);
      chk_idle_outputs("post_rst");

      drain("basic", 0, 0, 0, 1'b0, LAT);
      drain("stall", 2, 3, 0, 1'b0, LAT + 3);
      drain("bp",    0, 0, 4, 1'b0, LAT);
      drain("snap",  0, 0, 0, 1'b1, LAT);

      // Mid-drain reset after three transfers
      i_start = 1'b1;
      i_ready = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      edges   = 0;
      while (!o_valid && edges < 50) begin
         @(negedge i_clk);
         edges++;
      end
      chk("abort_rise_edge", 64'(edges), 64'(LAT));
      for (int k = 0; k < 3; k++) @(negedge i_clk);
      chk("abort_idx3", 64'(o_idx), 64'd3);
      chk("abort_data4", o_data, 64'd4);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk_idle_outputs("abort_rst");
      chk("abort_rst_busy", 64'(o_busy), 64'd0);
      chk("abort_rst_done", 64'(o_done), 64'd0);
      i_rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         chk("abort_nodone", 64'(o_done), 64'd0);
         chk("abort_idle",   64'(o_busy), 64'd0);
      end
      drain("restart", 0, 0, 0, 1'b0, LAT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
